mdu_unit: RTL and testbench

- Multiply/divide unit in the EX stage, directly downstream of the control decoder.
- Consumes the decoder's Start, MDUOP, Time and ReadHILO signals plus the forwarded rs/rt operands.
- Owns the architectural HI/LO registers and models multi-cycle latency with a busy countdown.
- Drives Busy to the hazard unit, which stalls MD-type instructions in D, and drives HILOOut to the E-stage result mux.

---
 rtl/mdu_pkg.sv | 30 +++
 rtl/mdu_calc.sv | 69 ++++++
 rtl/mdu_unit.sv | 102 ++++++++++
 tb/tb_mdu_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings and latency constants for the multiply/divide unit and its decoder.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'b0000,
    MDU_MULT  = 4'b0001,
    MDU_MULTU = 4'b0010,
    MDU_DIV   = 4'b0011,
    MDU_DIVU  = 4'b0100,
    MDU_MTHI  = 4'b0101,
    MDU_MTLO  = 4'b0110,
    MDU_MF    = 4'b1111
  } mdu_op_e;

  typedef enum logic [1:0] {
    RD_NONE = 2'b00,
    RD_LO   = 2'b01,
    RD_HI   = 2'b10,
    RD_RSVD = 2'b11
  } rd_hilo_e;

  localparam int MUL_TIME = 5;
  localparam int DIV_TIME = 10;

  function automatic logic is_md_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational result generator: 64-bit {HI,LO} image for mult/multu/div/divu.
module mdu_calc
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   hi_cur,
  input  logic [WIDTH-1:0]   lo_cur,
  output logic [2*WIDTH-1:0] res
);

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  logic signed [2*WIDTH-1:0] a_sx;
  logic signed [2*WIDTH-1:0] b_sx;
  logic signed [2*WIDTH-1:0] prod_s;
  logic        [2*WIDTH-1:0] prod_u;
  logic        [WIDTH-1:0]   a_mag;
  logic        [WIDTH-1:0]   b_mag;
  logic        [WIDTH-1:0]   quo_mag;
  logic        [WIDTH-1:0]   rem_mag;
  logic        [WIDTH-1:0]   quo_u;
  logic        [WIDTH-1:0]   rem_u;
  logic                      b_zero;

  assign a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_sx   = {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  // Signed divide on magnitudes: avoids the INT_MIN / -1 overflow and
  // yields truncation toward zero with the remainder following A's sign.
  assign a_mag   = magnitude(a);
  assign b_mag   = magnitude(b);
  assign b_zero  = (b == '0);
  assign quo_mag = b_zero ? '0 : (a_mag / b_mag);
  assign rem_mag = b_zero ? '0 : (a_mag % b_mag);
  assign quo_u   = b_zero ? '0 : (a / b);
  assign rem_u   = b_zero ? '0 : (a % b);

  always_comb begin
    res = {hi_cur, lo_cur};
    case (op)
      MDU_MULT:  res = prod_s;
      MDU_MULTU: res = prod_u;
      MDU_DIV: begin
        if (!b_zero) begin
          res = {negate_if(rem_mag, a[WIDTH-1]), negate_if(quo_mag, a[WIDTH-1] ^ b[WIDTH-1])};
        end
      end
      MDU_DIVU: begin
        if (!b_zero) begin
          res = {rem_u, quo_u};
        end
      end
      default: res = {hi_cur, lo_cur};
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// EX-stage multiply/divide unit: owns HI/LO, models latency with a busy countdown.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [3:0]       MDUOP,
  input  logic [CNT_W-1:0] Time,
  input  logic [1:0]       ReadHILO,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Req,
  output logic             Busy,
  output logic [WIDTH-1:0] HILOOut,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   pend_hi_q, pend_hi_d;
  logic [WIDTH-1:0]   pend_lo_q, pend_lo_d;
  logic [2*WIDTH-1:0] calc_res;
  logic               idle;
  logic               md_req;
  logic               accept;

  mdu_calc #(.WIDTH(WIDTH)) u_calc (
    .op     (MDUOP),
    .a      (A),
    .b      (B),
    .hi_cur (hi_q),
    .lo_cur (lo_q),
    .res    (calc_res)
  );

  assign idle   = (cnt_q == '0);
  assign md_req = Start & ~Req & is_md_op(MDUOP);
  assign accept = md_req & idle;
  assign Busy   = md_req | ~idle;

  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    if (accept) begin
      pend_hi_d = calc_res[2*WIDTH-1:WIDTH];
      pend_lo_d = calc_res[WIDTH-1:0];
      // Zero latency commits straight through at the accept edge.
      if (Time == '0) begin
        hi_d = calc_res[2*WIDTH-1:WIDTH];
        lo_d = calc_res[WIDTH-1:0];
      end else begin
        cnt_d = Time;
      end
    end else if (!idle) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else if (!Req) begin
      if (MDUOP == MDU_MTHI) hi_d = A;
      if (MDUOP == MDU_MTLO) lo_d = A;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  always_comb begin
    case (ReadHILO)
      RD_HI:   HILOOut = hi_q;
      RD_LO:   HILOOut = lo_q;
      default: HILOOut = '0;
    endcase
  end

  assign HI = hi_q;
  assign LO = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed and randomized checks of mdu_unit against an arithmetic reference model.
module tb_mdu_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [3:0]  MDUOP;
  logic [3:0]  Time;
  logic [1:0]  ReadHILO;
  logic [31:0] A;
  logic [31:0] B;
  logic        Req;
  logic        Busy;
  logic [31:0] HILOOut;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;
  logic [31:0] ref_hi = 32'h0;
  logic [31:0] ref_lo = 32'h0;

  mdu_unit #(.WIDTH(32), .CNT_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .Start    (Start),
    .MDUOP    (MDUOP),
    .Time     (Time),
    .ReadHILO (ReadHILO),
    .A        (A),
    .B        (B),
    .Req      (Req),
    .Busy     (Busy),
    .HILOOut  (HILOOut),
    .HI       (HI),
    .LO       (LO)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural result of an MD op, from plain 64-bit integer arithmetic.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] hi, input logic [31:0] lo);
    longint     sa, sb, q, r;
    logic [63:0] ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      MDU_MULT:  return 64'(sa * sb);
      MDU_MULTU: return ua * ub;
      MDU_DIV: begin
        if (b == 32'h0) return {hi, lo};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      MDU_DIVU: begin
        if (b == 32'h0) return {hi, lo};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return {hi, lo};
    endcase
  endfunction

  task automatic check_reads(input string tag);
    ReadHILO = 2'b10; #1;
    check32({tag, "_rd_hi"}, HILOOut, ref_hi);
    ReadHILO = 2'b01; #1;
    check32({tag, "_rd_lo"}, HILOOut, ref_lo);
    ReadHILO = 2'b11; #1;
    check32({tag, "_rd_11"}, HILOOut, 32'h0);
    ReadHILO = 2'b00;
  endtask

  task automatic do_mt(input logic [3:0] op, input logic [31:0] val, input string tag);
    MDUOP = op; A = val; Req = 1'b0; #1;
    check1({tag, "_busy"}, Busy, 1'b0);
    tick();
    MDUOP = MDU_NONE; A = $urandom; #1;
    check1({tag, "_busy_after"}, Busy, 1'b0);
    if (op == MDU_MTHI) ref_hi = val;
    else ref_lo = val;
    check32({tag, "_hi"}, HI, ref_hi);
    check32({tag, "_lo"}, LO, ref_lo);
  endtask

  // Launch one MD op and follow it cycle by cycle through commit.
  task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] t, input string tag);
    logic [63:0] exp;
    check1({tag, "_idle_before_start"}, Busy, 1'b0);
    exp = model(op, a, b, ref_hi, ref_lo);
    Start = 1'b1; MDUOP = op; Time = t; A = a; B = b; #1;
    check1({tag, "_busy_c0"}, Busy, 1'b1);
    tick();
    Start = 1'b0; Time = 4'($urandom);
    MDUOP = (t != 4'd0) ? MDU_MTHI : MDU_NONE;
    A = $urandom; B = $urandom; #1;
    for (int c = 1; c <= int'(t); c++) begin
      check1({tag, "_busy_run"}, Busy, 1'b1);
      check32({tag, "_hi_run"}, HI, ref_hi);
      check32({tag, "_lo_run"}, LO, ref_lo);
      if (c == int'(t)) MDUOP = MDU_NONE;
      tick();
    end
    #1;
    ref_hi = exp[63:32];
    ref_lo = exp[31:0];
    check1({tag, "_busy_done"}, Busy, 1'b0);
    check32({tag, "_hi"}, HI, ref_hi);
    check32({tag, "_lo"}, LO, ref_lo);
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;

    reset = 1'b0; Start = 1'b0; Req = 1'b0; MDUOP = MDU_NONE; Time = 4'd0;
    ReadHILO = 2'b00; A = 32'h0; B = 32'h0;
    #2;
    check1("reset_busy", Busy, 1'b0);
    check32("reset_hi", HI, 32'h0);
    check32("reset_lo", LO, 32'h0);
    check_reads("reset");
    #10 reset = 1'b1;
    tick();

    run_md(MDU_MULT, 32'hFFFFFFFE, 32'd3, 4'(MUL_TIME), "mult_neg");
    check_reads("mult_neg");
    run_md(MDU_MULTU, 32'hFFFFFFFF, 32'd2, 4'(MUL_TIME), "multu");
    run_md(MDU_DIV, 32'hFFFFFFF9, 32'd2, 4'(DIV_TIME), "div_neg");
    check32("div_neg_lo_literal", LO, 32'hFFFFFFFD);
    check32("div_neg_hi_literal", HI, 32'hFFFFFFFF);

    do_mt(MDU_MTHI, 32'h11, "mthi11");
    do_mt(MDU_MTLO, 32'h22, "mtlo22");
    run_md(MDU_DIV, 32'd5, 32'd0, 4'(DIV_TIME), "div_by_zero");
    check32("div0_hi_literal", HI, 32'h11);
    check32("div0_lo_literal", LO, 32'h22);
    run_md(MDU_DIVU, 32'd9, 32'd0, 4'(DIV_TIME), "divu_by_zero");

    do_mt(MDU_MTHI, 32'h1234, "mthi1234");
    ReadHILO = 2'b10; #1;
    check32("mthi_readback", HILOOut, 32'h1234);
    ReadHILO = 2'b00;

    run_md(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 4'(DIV_TIME), "div_intmin");
    check32("intmin_lo_literal", LO, 32'h80000000);
    check32("intmin_hi_literal", HI, 32'h0);
    run_md(MDU_DIVU, 32'hFFFFFFF0, 32'd7, 4'(DIV_TIME), "divu");
    run_md(MDU_MULT, 32'h12345678, 32'hFEDCBA98, 4'd0, "mult_time0");

    // Flush request blocks both a launch and an mt write.
    Start = 1'b1; Req = 1'b1; MDUOP = MDU_MULT; Time = 4'(MUL_TIME);
    A = 32'h7; B = 32'h9; #1;
    check1("req_busy", Busy, 1'b0);
    tick();
    Start = 1'b0; #1;
    check1("req_busy_next", Busy, 1'b0);
    MDUOP = MDU_MTLO; A = 32'hDEADBEEF;
    tick();
    Req = 1'b0; MDUOP = MDU_NONE;
    repeat (6) tick();
    check1("req_busy_late", Busy, 1'b0);
    check32("req_hi", HI, ref_hi);
    check32("req_lo", LO, ref_lo);

    // Reset mid-run: state clears immediately, no commit later.
    check1("rst_idle_before_start", Busy, 1'b0);
    Start = 1'b1; MDUOP = MDU_MULT; Time = 4'(MUL_TIME); A = 32'hFFFFFFFD; B = 32'd7; #1;
    check1("rst_busy_c0", Busy, 1'b1);
    tick();
    Start = 1'b0; MDUOP = MDU_NONE;
    tick();
    tick();
    #1 reset = 1'b0;
    #1;
    ref_hi = 32'h0; ref_lo = 32'h0;
    check1("rst_mid_busy", Busy, 1'b0);
    check32("rst_mid_hi", HI, 32'h0);
    check32("rst_mid_lo", LO, 32'h0);
    @(negedge clk) reset = 1'b1;
    repeat (8) tick();
    check1("rst_after_busy", Busy, 1'b0);
    check32("rst_after_hi", HI, 32'h0);
    check32("rst_after_lo", LO, 32'h0);

    for (int i = 0; i < 24; i++) begin
      rop = 4'($urandom_range(1, 4));
      ra = $urandom;
      if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = 32'hFFFFFFFF;
        2:       rb = 32'h1;
        3:       rb = 32'($urandom_range(2, 100));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) do_mt(MDU_MTLO, $urandom, "rand_mtlo");
      run_md(rop, ra, rb, (rop <= MDU_MULTU) ? 4'(MUL_TIME) : 4'(DIV_TIME), "rand");
      if (i % 6 == 0) check_reads("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
